// File: rtl/sqrt_arbiter_if.sv
// rtl/sqrt_arbiter_if.sv - requester and square-root unit signals of sqrt_arbiter
interface sqrt_arbiter_if;
  logic [3:0]  req_valid_i;
  logic [63:0] req_value_i;
  logic [3:0]  req_ack_o;
  logic [3:0]  resp_valid_o;
  logic [7:0]  resp_root_o;
  logic        err_o;
  logic        busy_o;
  logic        sq_start_o;
  logic [15:0] sq_value_o;
  logic        sq_ready_i;
  logic [7:0]  sq_root_i;

  modport slave (
    input  req_valid_i, req_value_i, sq_ready_i, sq_root_i,
    output req_ack_o, resp_valid_o, resp_root_o, err_o, busy_o, sq_start_o, sq_value_o
  );

  modport master (
    output req_valid_i, req_value_i, sq_ready_i, sq_root_i,
    input  req_ack_o, resp_valid_o, resp_root_o, err_o, busy_o, sq_start_o, sq_value_o
  );
endinterface

// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin arbiter sharing one square-root unit among 4 requesters
// Optional WAIT watchdog enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter #(
  parameter int NREQ           = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic           clk,
  input logic           rst_n,
  sqrt_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    r_state;
  logic [IW-1:0] r_rr_ptr;
  logic [IW-1:0] r_idx;
  logic [15:0]   r_value;
  logic [7:0]    r_root;

  logic          w_any;
  logic [IW-1:0] w_pick;
  logic [IW-1:0] w_cand;
  logic          w_timeout;

  // Scan farthest offset first so the nearest requester at or above rr_ptr wins; wrap is modulo NREQ.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_rr_ptr;
    w_cand = r_rr_ptr;
    for (int i = NREQ - 1; i >= 0; i--) begin
      w_cand = r_rr_ptr + IW'(i);
      if (bus.req_valid_i[w_cand]) begin
        w_any  = 1'b1;
        w_pick = w_cand;
      end
    end
  end

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_wait_cnt;
  logic          r_err;

  assign w_timeout = (r_wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == S_ISSUE) begin
        r_wait_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
      if (r_state == S_WAIT) begin
        r_err <= !bus.sq_ready_i && w_timeout;
      end
    end
  end

  assign bus.err_o = (r_state == S_RESP) && r_err;
`else
  logic w_unused_tmo;

  assign w_timeout    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYCLES > 0);
  assign bus.err_o    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_idx    <= '0;
      r_value  <= '0;
      r_root   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_idx   <= w_pick;
            r_value <= bus.req_value_i[{w_pick, 4'b0000} +: 16];
            r_state <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          if (bus.sq_ready_i) begin
            r_root  <= bus.sq_root_i;
            r_state <= S_RESP;
          end else if (w_timeout) begin
            r_root  <= 8'hFF;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_rr_ptr <= r_idx + 1'b1;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ack_o    = (r_state == S_ISSUE) ? (4'b0001 << r_idx) : 4'b0000;
  assign bus.resp_valid_o = (r_state == S_RESP)  ? (4'b0001 << r_idx) : 4'b0000;
  assign bus.resp_root_o  = r_root;
  assign bus.busy_o       = (r_state != S_IDLE);
  assign bus.sq_start_o   = (r_state == S_ISSUE);
  assign bus.sq_value_o   = (r_state == S_IDLE) ? 16'd0 : r_value;
endmodule

// File: tb/tb_sqrt_arbiter.sv
// tb/tb_sqrt_arbiter.sv - scoreboard bench for sqrt_arbiter with a randomized square-root unit model
module tb_sqrt_arbiter;
  localparam int TMO = 8;

  typedef struct {
    int         k;
    logic [7:0] root;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sqrt_arbiter_if dut_if ();

  sqrt_arbiter #(.NREQ(4), .TIMEOUT_CYCLES(TMO)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dut_if.slave)
  );

  exp_t exp_q[$];
  int   lat_q[$];
  int   dgrants[$];
  int   fixed_delay = 0;
  bit   never = 1'b0;
  bit   junk_en = 1'b1;
  bit   hold_all = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] isqrt(input logic [15:0] v);
    int r = 0;
    while ((r + 1) * (r + 1) <= int'(v)) r++;
    return 8'(r);
  endfunction

  function automatic int rr_pick(input logic [3:0] v, input int ptr);
    for (int i = 0; i < 4; i++) if (v[(ptr + i) % 4]) return (ptr + i) % 4;
    return -1;
  endfunction

  function automatic int onehot_idx(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [34:0] outs();
    return {dut_if.req_ack_o, dut_if.resp_valid_o, dut_if.resp_root_o, dut_if.err_o,
            dut_if.busy_o, dut_if.sq_start_o, dut_if.sq_value_o};
  endfunction

  // Monitor, scoreboard and square-root unit model share one process on the falling edge.
  initial begin
    int         k;
    int         m_ptr;
    exp_t       e;
    logic [15:0] v;
    logic [3:0] prev_valid;
    logic [63:0] prev_value;
    logic       prev_busy;
    logic       prev_resp;
    logic [15:0] cur_val;
    logic [7:0] last_root;
    logic       tmo;
    int         sq_cnt;
    logic [7:0] sq_result;
    m_ptr = 0; prev_valid = '0; prev_value = '0; prev_busy = 1'b0; prev_resp = 1'b0;
    cur_val = '0; last_root = '0; sq_cnt = 0; sq_result = '0;
    dut_if.sq_ready_i = 1'b0;
    dut_if.sq_root_i  = '0;
    forever begin
      @(negedge clk);
`ifdef SQRT_ARB_TIMEOUT_EN
      tmo = never;
`else
      tmo = 1'b0;
`endif
      if (!rst_n) begin
        m_ptr = 0; prev_valid = '0; prev_busy = 1'b0; prev_resp = 1'b0;
        cur_val = '0; last_root = '0;
        exp_q.delete();
        lat_q.delete();
      end else begin
        if (!prev_busy) begin
          k = rr_pick(prev_valid, m_ptr);
          check("grant", dut_if.req_ack_o, (k < 0) ? 4'b0000 : (4'b0001 << k));
          check("start", dut_if.sq_start_o, k >= 0);
          check("busy_after_idle", dut_if.busy_o, k >= 0);
          if (k >= 0) begin
            v = prev_value[16*k +: 16];
            check("issue_value", dut_if.sq_value_o, v);
            cur_val = v;
            exp_q.push_back('{k, tmo ? 8'hFF : isqrt(v), tmo});
            m_ptr = (k + 1) % 4;
          end
        end else begin
          check("ack_quiet", {dut_if.req_ack_o, dut_if.sq_start_o}, 5'b0);
          if (dut_if.busy_o) check("value_hold", dut_if.sq_value_o, cur_val);
        end
        if (prev_resp) check("idle_after_resp", dut_if.busy_o, 1'b0);
        if (!dut_if.busy_o) check("value_idle", dut_if.sq_value_o, 16'd0);

        if (dut_if.resp_valid_o != 4'b0000) begin
          if (exp_q.size() == 0) begin
            check("resp_unexpected", dut_if.resp_valid_o, 4'b0000);
          end else begin
            e = exp_q.pop_front();
            check("resp_valid", dut_if.resp_valid_o, 4'b0001 << e.k);
            check("resp_root", dut_if.resp_root_o, e.root);
            check("resp_err", dut_if.err_o, e.err);
            last_root = e.root;
            if (lat_q.size() > 0) check("resp_cycle", cyc, lat_q.pop_front());
          end
          prev_resp = 1'b1;
        end else begin
          check("root_hold", dut_if.resp_root_o, last_root);
          check("err_quiet", dut_if.err_o, 1'b0);
          prev_resp = 1'b0;
        end
        prev_busy = dut_if.busy_o;
      end
      prev_valid = dut_if.req_valid_i;
      prev_value = dut_if.req_value_i;

      if (rst_n && dut_if.sq_start_o) begin
        sq_cnt    = never ? -1 : (fixed_delay > 0 ? fixed_delay : int'($urandom_range(1, 6)));
        sq_result = isqrt(dut_if.sq_value_o);
        lat_q.push_back(cyc + (never ? TMO : sq_cnt) + 1);
        dut_if.sq_ready_i = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
        dut_if.sq_root_i  = 8'($urandom);
      end else if (sq_cnt > 0) begin
        sq_cnt--;
        dut_if.sq_ready_i = (sq_cnt == 0);
        dut_if.sq_root_i  = (sq_cnt == 0) ? sq_result : 8'($urandom);
      end else if (sq_cnt < 0) begin
        dut_if.sq_ready_i = 1'b0;
      end else begin
        dut_if.sq_ready_i = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
        dut_if.sq_root_i  = 8'($urandom);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (dut_if.req_ack_o != 4'b0000) begin
      dgrants.push_back(onehot_idx(dut_if.req_ack_o));
      if (!hold_all) dut_if.req_valid_i = dut_if.req_valid_i & ~dut_if.req_ack_o;
    end
  endtask

  task automatic raise(input int k, input logic [15:0] v);
    dut_if.req_valid_i[k] = 1'b1;
    dut_if.req_value_i[16*k +: 16] = v;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", outs(), 35'd0);
    dut_if.req_valid_i = 4'b0000;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  task automatic wait_resp(input int limit, output logic [7:0] root, output logic err, output int at);
    at = -1; root = '0; err = 1'b0;
    for (int i = 0; i < limit && at < 0; i++) begin
      step();
      if (dut_if.resp_valid_o != 4'b0000) begin
        root = dut_if.resp_root_o;
        err  = dut_if.err_o;
        at   = cyc;
      end
    end
    if (at < 0) check("resp_wait_expired", 1'b0, 1'b1);
  endtask

  task automatic wait_grants(input int n, input int limit);
    int target = dgrants.size() + n;
    int i = 0;
    while (dgrants.size() < target && i < limit) begin
      step();
      i++;
    end
    if (dgrants.size() < target) check("grant_wait_expired", dgrants.size(), target);
  endtask

  task automatic drain(input int limit);
    int i = 0;
    while ((dut_if.req_valid_i != 4'b0000 || dut_if.busy_o) && i < limit) begin
      step();
      i++;
    end
    check("drained", {dut_if.req_valid_i, dut_if.busy_o}, 5'b0);
  endtask

  function automatic logic [15:0] pick_val();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [7:0] root;
    logic       err;
    int         at;
    int         t0;
    int         base;
    int         cnt;
    int         ord5[5];
    int         ord3[3];
    dut_if.req_valid_i = '0;
    dut_if.req_value_i = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", outs(), 35'd0);
    #1;
    rst_n = 1'b1;

    // Single request, unit ready 5 cycles after start.
    fixed_delay = 5;
    step();
    raise(2, 16'd144);
    t0 = cyc;
    wait_resp(40, root, err, at);
    check("latency", at - t0 + 1, 8);
    check("root_144", root, 8'd12);
    check("grant_first", dgrants[$], 2);
    fixed_delay = 0;
    drain(40);

    // All four held: rotation from a fresh pointer.
    do_reset();
    base = dgrants.size();
    hold_all = 1'b1;
    for (int k = 0; k < 4; k++) raise(k, pick_val());
    wait_grants(5, 200);
    hold_all = 1'b0;
    dut_if.req_valid_i = 4'b0000;
    ord5 = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) check("rr_order", dgrants[base + i], ord5[i]);
    drain(40);

    // After grant 2, requesters 0 and 3 wait: 3 goes before 0.
    base = dgrants.size();
    raise(2, pick_val());
    wait_grants(1, 20);
    raise(0, pick_val());
    raise(3, pick_val());
    wait_grants(2, 60);
    ord3 = '{2, 3, 0};
    for (int i = 0; i < 3; i++) check("wrap_order", dgrants[base + i], ord3[i]);
    drain(60);

    // Radicand extremes.
    raise(1, 16'h0000);
    wait_resp(40, root, err, at);
    check("root_zero", root, 8'd0);
    raise(1, 16'hFFFF);
    wait_resp(40, root, err, at);
    check("root_max", root, 8'd255);
    drain(40);

    // Reset in WAIT: late ready pulse must not produce a response; pointer returns to 0.
    raise(1, pick_val());
    wait_resp(40, root, err, at);
    drain(40);
    fixed_delay = 10;
    raise(2, 16'd400);
    wait_grants(1, 20);
    repeat (3) step();
    do_reset();
    fixed_delay = 0;
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (dut_if.resp_valid_o != 4'b0000 || dut_if.busy_o) cnt++;
    end
    check("quiet_after_reset", cnt, 0);
    raise(1, pick_val());
    raise(2, pick_val());
    wait_grants(1, 10);
    check("ptr_after_reset", dgrants[$], 1);
    drain(60);

    // Unit never answers.
    never = 1'b1;
    raise(3, 16'd1000);
`ifdef SQRT_ARB_TIMEOUT_EN
    wait_resp(40, root, err, at);
    check("timeout_root", root, 8'hFF);
    check("timeout_err", err, 1'b1);
    never = 1'b0;
    drain(40);
`else
    wait_grants(1, 10);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (dut_if.busy_o) cnt++;
    end
    check("wait_unbounded", cnt, 40);
    never = 1'b0;
    do_reset();
`endif

    // Random traffic with random unit delays, late raises and abandoned requests.
    for (int c = 0; c < 2500; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (!dut_if.req_valid_i[k]) begin
          if ($urandom_range(0, 5) == 0) raise(k, pick_val());
        end else if ($urandom_range(0, 63) == 0) begin
          dut_if.req_valid_i[k] = 1'b0;
        end
      end
      step();
    end
    drain(200);
    repeat (3) step();
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1);
  end
endmodule
